arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- Writer-side counterpart to the cracking datapath: encrypts a length-prefixed plaintext from pt_mem with a 24-bit ARC4 key and writes the length-prefixed ciphertext into ct_mem.
- The cracker and decrypt blocks later read that ct_mem.
- Sits beside the cracker in the top level and shares its en/rdy handshake convention.
- Owns one S-box memory through an external port set.

Parameters:
- KEY_BYTES, 3, number of key bytes. The key schedule is fixed at 3.
- MSG_MAX, 255, maximum message length in bytes. Bounded by the 8-bit address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  high when idle and able to accept en
- key  input  24  ARC4 key; key[23:16] is key byte 0, key[7:0] is key byte 2
- pt_addr  output  8  plaintext memory address
- pt_rddata  input  8  plaintext read data; 1-cycle synchronous latency
- s_addr  output  8  S memory address
- s_rddata  input  8  S memory read data; 1-cycle latency
- s_wrdata  output  8  S memory write data
- s_wren  output  1  S memory write enable
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: rdy=1; s_wren=0, ct_wren=0; all addresses and write data 0; FSM in IDLE.
- Reset mid-operation: aborts immediately. No further writes occur. Memory contents already written are left as-is.

Handshake:
- en=1 while rdy=1 on a rising edge starts a job.
- key is latched on that edge. Later key changes do not affect the job.
- rdy falls on the following cycle and stays low until the job completes.
- rdy returns to 1 in the cycle after the last ct write.
- en while rdy=0 is ignored. en held high continuously causes back-to-back jobs.

Memories:
- Read data is valid one cycle after the address is presented.
- A write takes effect on the edge where wren=1.
- At most one S access per cycle.

FSM states: IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR_I, KSA_WR_J, LEN_RD, LEN_WR, PRGA_RD_I, PRGA_RD_J, PRGA_WR_I, PRGA_WR_J, PRGA_RD_K, PRGA_RD_PT, PRGA_WR_CT, DONE.
- INIT: write s[i]=i for i=0..255, one write per cycle, 256 cycles.
- KSA, for i=0..255:
  - j = j + s[i] + keybyte[i mod 3], all arithmetic mod 256, with j reset to 0 at KSA start.
  - Swap s[i] and s[j].
  - The i mod 3 selector uses a 2-bit rolling counter, not a divider.
- LEN: read pt[0] into L; write ct[0]=L.
- PRGA, for k=1..L:
  - i = i+1, j = j+s[i], both mod 256; i and j restart at 0.
  - Swap s[i] and s[j].
  - pad = s[(s[i]+s[j]) mod 256], using the pre-swap values (equivalent to post-swap sum).
  - Write ct[k] = pt[k] XOR pad.
- Swap when i==j: both writes carry the same value, and S is unchanged. The swap values are captured in registers before either write.
- L=0: only ct[0]=0 is written. Go straight to DONE with no PRGA iterations.
- L=255: the last write is to ct[255]. The k counter is 9-bit internally so the final iteration is detectable without wrap.
- ct_wren pulses for exactly one cycle per byte. Total ct writes per job = L+1, at addresses 0..L in increasing order.
- pt_addr never exceeds L. s_wren and ct_wren are never asserted in IDLE.
- Latency: roughly 256 + 256×~5 + 2 + L×~8 cycles. Only ordering and the result are normative.

Decomposition:
- Shared package arc4_pkg holds:
  - enum state_t
  - constant S_SIZE=256
  - function key_byte(key, idx) that returns the byte by i mod 3
- The same package is reused by the decrypt/crack blocks.
- One natural sub-module, arc4_ksa_prga_ctl: the i/j/k counters and the swap-capture registers. The top FSM sequences the phases.

Test Plan:
- Reset, then idle → rdy=1; s_wren=0, ct_wren=0. With en held low for 100 cycles, zero memory writes occur.
- Known-answer vector:
  - Stimulus: key=24'h4B6579 ("Key"), pt={09,"Plaintext"}, pulse en.
  - Required response: ct[0..9] = 09 BB F3 16 E8 D9 40 AF 0A D3; exactly 10 ct writes; rdy returns to 1.
- L=0: key=24'h000000, pt[0]=00 → one ct write (ct[0]=00), then rdy=1. The PRGA states are never entered (checked via a coverage point).
- Round trip at full length:
  - Stimulus: random key, L=255, random pt.
  - Required response: running the ct through the existing decrypt model with the same key returns the pt. The last write is to ct_addr=255.
- Disturbance during a job:
  - Stimulus: toggle en and change key while busy.
  - Required response: the output equals the result for the originally latched key; no second job starts until rdy=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during PRGA, k=4.
  - Required response: ct_wren=0 immediately and rdy=1 while reset is held. A subsequent job with the same inputs produces the correct full result.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 state encoding, S-box size and key byte selection
package arc4_pkg;

   localparam int S_SIZE = 256;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      KSA_RD_I,
      KSA_RD_J,
      KSA_WR_I,
      KSA_WR_J,
      LEN_RD,
      LEN_WR,
      PRGA_RD_I,
      PRGA_RD_J,
      PRGA_WR_I,
      PRGA_WR_J,
      PRGA_RD_K,
      PRGA_RD_PT,
      PRGA_WR_CT,
      DONE
   } state_t;

   // idx is the rolling i mod 3 selector; byte 0 is the most significant key byte
   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
      case (idx)
         2'd0:    key_byte = key[23:16];
         2'd1:    key_byte = key[15:8];
         default: key_byte = key[7:0];
      endcase
   endfunction

endpackage

// File: rtl/arc4_ksa_prga_ctl.sv
// rtl/arc4_ksa_prga_ctl.sv - i/j/k counters and swap-capture registers for KSA and PRGA
module arc4_ksa_prga_ctl #(
   parameter int KEY_BYTES = 3,
   parameter int K_W       = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr_ij,
   input  logic           inc_i,
   input  logic           ld_j,
   input  logic [7:0]     j_add,
   input  logic [7:0]     s_rddata,
   input  logic           cap_si,
   input  logic           cap_sj,
   input  logic           clr_k,
   input  logic           inc_k,
   output logic [7:0]     i,
   output logic [7:0]     i_inc,
   output logic [7:0]     j,
   output logic [7:0]     j_sum,
   output logic [7:0]     si,
   output logic [7:0]     sj,
   output logic [1:0]     ksel,
   output logic [K_W-1:0] k
);

   assign i_inc = i + 8'd1;
   // j_add carries the key byte during KSA and zero during PRGA
   assign j_sum = j + s_rddata + j_add;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i    <= 8'd0;
         j    <= 8'd0;
         ksel <= 2'd0;
         si   <= 8'd0;
         sj   <= 8'd0;
         k    <= '0;
      end else begin
         if (clr_ij) begin
            i    <= 8'd0;
            j    <= 8'd0;
            ksel <= 2'd0;
         end else begin
            if (inc_i) begin
               i    <= i_inc;
               ksel <= (ksel == 2'(KEY_BYTES - 1)) ? 2'd0 : ksel + 2'd1;
            end
            if (ld_j) j <= j_sum;
         end
         if (cap_si) si <= s_rddata;
         if (cap_sj) sj <= s_rddata;
         if (clr_k)
            k <= K_W'(1);
         else if (inc_k)
            k <= k + 1'b1;
      end
   end

endmodule

// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - ARC4 encryptor: length-prefixed pt_mem to length-prefixed ct_mem
module arc4_encrypt
   import arc4_pkg::*;
#(
   parameter int KEY_BYTES = 3,
   parameter int MSG_MAX   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  s_addr,
   input  logic [7:0]  s_rddata,
   output logic [7:0]  s_wrdata,
   output logic        s_wren,
   output logic [7:0]  ct_addr,
   output logic [7:0]  ct_wrdata,
   output logic        ct_wren
);

   // one extra bit so k reaching L=255 is seen without wrapping
   localparam int K_W = $clog2(MSG_MAX + 2);

   state_t state, nxt;

   logic [23:0]    key_q;
   logic [7:0]     len_q;
   logic [7:0]     pad_q;
   logic           start, cap_pad;
   logic           clr_ij, inc_i, ld_j, cap_si, cap_sj, clr_k, inc_k;
   logic [7:0]     j_add;
   logic [7:0]     i, i_inc, j, j_sum, si, sj;
   logic [1:0]     ksel;
   logic [K_W-1:0] k;

   arc4_ksa_prga_ctl #(
      .KEY_BYTES(KEY_BYTES),
      .K_W      (K_W)
   ) u_ctl (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_ij  (clr_ij),
      .inc_i   (inc_i),
      .ld_j    (ld_j),
      .j_add   (j_add),
      .s_rddata(s_rddata),
      .cap_si  (cap_si),
      .cap_sj  (cap_sj),
      .clr_k   (clr_k),
      .inc_k   (inc_k),
      .i       (i),
      .i_inc   (i_inc),
      .j       (j),
      .j_sum   (j_sum),
      .si      (si),
      .sj      (sj),
      .ksel    (ksel),
      .k       (k)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= 24'd0;
         len_q <= 8'd0;
         pad_q <= 8'd0;
      end else begin
         if (start)            key_q <= key;
         if (state == LEN_WR)  len_q <= pt_rddata;
         if (cap_pad)          pad_q <= s_rddata;
      end
   end

   always_comb begin
      nxt       = state;
      rdy       = 1'b0;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      pt_addr   = 8'd0;
      ct_addr   = 8'd0;
      ct_wrdata = 8'd0;
      ct_wren   = 1'b0;
      start     = 1'b0;
      cap_pad   = 1'b0;
      clr_ij    = 1'b0;
      inc_i     = 1'b0;
      ld_j      = 1'b0;
      j_add     = 8'd0;
      cap_si    = 1'b0;
      cap_sj    = 1'b0;
      clr_k     = 1'b0;
      inc_k     = 1'b0;

      case (state)
         // DONE behaves like IDLE so en held high starts the next job at once
         IDLE, DONE: begin
            rdy = 1'b1;
            if (en) begin
               start  = 1'b1;
               clr_ij = 1'b1;
               nxt    = INIT;
            end else begin
               nxt = IDLE;
            end
         end
         INIT: begin
            s_addr   = i;
            s_wrdata = i;
            s_wren   = 1'b1;
            if (i == 8'(S_SIZE - 1)) begin
               clr_ij = 1'b1;
               nxt    = KSA_RD_I;
            end else begin
               inc_i = 1'b1;
            end
         end
         KSA_RD_I: begin
            s_addr = i;
            nxt    = KSA_RD_J;
         end
         KSA_RD_J: begin
            j_add  = key_byte(key_q, ksel);
            ld_j   = 1'b1;
            cap_si = 1'b1;
            s_addr = j_sum;
            nxt    = KSA_WR_I;
         end
         // s[j] arrives here; it is written to s[i] and captured in the same cycle
         KSA_WR_I: begin
            cap_sj   = 1'b1;
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            nxt      = KSA_WR_J;
         end
         KSA_WR_J: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            if (i == 8'(S_SIZE - 1)) begin
               nxt = LEN_RD;
            end else begin
               inc_i = 1'b1;
               nxt   = KSA_RD_I;
            end
         end
         LEN_RD: begin
            pt_addr = 8'd0;
            nxt     = LEN_WR;
         end
         LEN_WR: begin
            ct_addr   = 8'd0;
            ct_wrdata = pt_rddata;
            ct_wren   = 1'b1;
            clr_ij    = 1'b1;
            clr_k     = 1'b1;
            nxt       = (pt_rddata == 8'd0) ? DONE : PRGA_RD_I;
         end
         PRGA_RD_I: begin
            s_addr = i_inc;
            inc_i  = 1'b1;
            nxt    = PRGA_RD_J;
         end
         PRGA_RD_J: begin
            ld_j   = 1'b1;
            cap_si = 1'b1;
            s_addr = j_sum;
            nxt    = PRGA_WR_I;
         end
         PRGA_WR_I: begin
            cap_sj   = 1'b1;
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            nxt      = PRGA_WR_J;
         end
         PRGA_WR_J: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            nxt      = PRGA_RD_K;
         end
         PRGA_RD_K: begin
            s_addr = si + sj;
            nxt    = PRGA_RD_PT;
         end
         PRGA_RD_PT: begin
            cap_pad = 1'b1;
            pt_addr = k[7:0];
            nxt     = PRGA_WR_CT;
         end
         PRGA_WR_CT: begin
            ct_addr   = k[7:0];
            ct_wrdata = pt_rddata ^ pad_q;
            ct_wren   = 1'b1;
            if (k == K_W'(len_q)) begin
               nxt = DONE;
            end else begin
               inc_k = 1'b1;
               nxt   = PRGA_RD_I;
            end
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb/tb_arc4_encrypt.sv - self-checking bench for arc4_encrypt with memory models and scoreboard
module tb_arc4_encrypt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [23:0] key = 24'd0;
   logic        rdy;
   logic [7:0]  pt_addr, pt_rddata, s_addr, s_rddata, s_wrdata, ct_addr, ct_wrdata;
   logic        s_wren, ct_wren;

   logic [7:0]  s_mem  [256];
   logic [7:0]  pt_mem [256];
   logic [7:0]  ct_mem [256];
   logic [7:0]  ks     [256];
   logic [15:0] exp_q  [$];

   logic [7:0] kat_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] kat_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   int n_cmp = 0;
   int n_err = 0;
   int ct_wr_cnt = 0;
   int s_wr_cnt = 0;
   int rst_wr_cnt = 0;
   int cyc = 0;
   int last_wr_cyc = 0;
   int last_wr_addr = 0;

   always #5 clk = ~clk;

   arc4_encrypt dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .rdy      (rdy),
      .key      (key),
      .pt_addr  (pt_addr),
      .pt_rddata(pt_rddata),
      .s_addr   (s_addr),
      .s_rddata (s_rddata),
      .s_wrdata (s_wrdata),
      .s_wren   (s_wren),
      .ct_addr  (ct_addr),
      .ct_wrdata(ct_wrdata),
      .ct_wren  (ct_wren)
   );

   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         if (s_wren || ct_wren) rst_wr_cnt <= rst_wr_cnt + 1;
      end else begin
         if (s_wren)  s_wr_cnt  <= s_wr_cnt + 1;
         if (ct_wren) ct_wr_cnt <= ct_wr_cnt + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=time-limit expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference ARC4 keystream, ks[n] is the pad for ct[n+1]
   task automatic gen_ks(input logic [23:0] k_in);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] t;
      int a, b;
      kb[0] = k_in[23:16];
      kb[1] = k_in[15:8];
      kb[2] = k_in[7:0];
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      b = 0;
      for (int n = 0; n < 256; n++) begin
         b = (b + int'(s[n]) + int'(kb[n % 3])) % 256;
         t = s[n]; s[n] = s[b]; s[b] = t;
      end
      a = 0;
      b = 0;
      for (int n = 0; n < 256; n++) begin
         a = (a + 1) % 256;
         b = (b + int'(s[a])) % 256;
         t = s[a]; s[a] = s[b]; s[b] = t;
         ks[n] = s[(int'(s[a]) + int'(s[b])) % 256];
      end
   endtask

   task automatic push_exp(input logic [23:0] k_in);
      int len;
      gen_ks(k_in);
      len = int'(pt_mem[0]);
      exp_q.delete();
      exp_q.push_back({8'h00, pt_mem[0]});
      for (int n = 1; n <= len; n++) exp_q.push_back({8'(n), pt_mem[n] ^ ks[n-1]});
   endtask

   task automatic start_job(input logic [23:0] k_in);
      @(negedge clk);
      key = k_in;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      chk("rdy_fall", 64'(rdy), 64'd0);
   endtask

   // scoreboard loop: pops one expected entry per ct write; stops at rdy or at abort_at write
   task automatic run_wait(input string tag, input int budget, input int abort_at);
      int  c;
      bit  done;
      c = 0;
      done = 1'b0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
         if (ct_wren) begin
            last_wr_cyc  = cyc;
            last_wr_addr = int'(ct_addr);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $error("FAIL %s_ct_extra observed=%0h expected=no-write", tag, {ct_addr, ct_wrdata});
            end else begin
               chk({tag, "_ct"}, 64'({ct_addr, ct_wrdata}), 64'(exp_q.pop_front()));
            end
            if (int'(ct_addr) == abort_at) done = 1'b1;
         end
         if (rdy) done = 1'b1;
      end
      chk({tag, "_finished"}, 64'(done), 64'd1);
   endtask

   task automatic run_job(input string tag, input logic [23:0] k_in);
      int base;
      int len;
      len  = int'(pt_mem[0]);
      push_exp(k_in);
      base = ct_wr_cnt;
      start_job(k_in);
      run_wait(tag, 6000, -1);
      chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_ct_count"}, 64'(ct_wr_cnt - base), 64'(len + 1));
      chk({tag, "_rdy_latency"}, 64'(cyc - last_wr_cyc), 64'd1);
   endtask

   initial begin
      int base_ct, base_s, bad;
      logic [23:0] rk;

      for (int n = 0; n < 256; n++) pt_mem[n] = 8'd0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({rdy, s_wren, ct_wren, s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata}),
          64'({1'b1, 42'd0}));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outputs", 64'({rdy, s_wren, ct_wren, s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata}),
          64'({1'b1, 42'd0}));

      base_ct = ct_wr_cnt;
      base_s  = s_wr_cnt;
      repeat (100) @(negedge clk);
      chk("idle_no_writes", 64'((ct_wr_cnt - base_ct) + (s_wr_cnt - base_s)), 64'd0);
      chk("idle_rdy", 64'(rdy), 64'd1);

      for (int n = 0; n < 10; n++) pt_mem[n] = kat_pt[n];
      run_job("kat", 24'h4B6579);
      for (int n = 0; n < 10; n++) chk($sformatf("kat_byte%0d", n), 64'(ct_mem[n]), 64'(kat_ct[n]));

      pt_mem[0] = 8'd0;
      base_s = s_wr_cnt;
      run_job("len0", 24'h000000);
      chk("len0_ct0", 64'(ct_mem[0]), 64'd0);
      chk("len0_no_prga_swaps", 64'(s_wr_cnt - base_s), 64'd768);

      rk = 24'($urandom);
      pt_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
      base_s = s_wr_cnt;
      run_job("full", rk);
      gen_ks(rk);
      bad = 0;
      for (int n = 1; n < 256; n++) if ((ct_mem[n] ^ ks[n-1]) !== pt_mem[n]) bad++;
      chk("full_roundtrip_bad", 64'(bad), 64'd0);
      chk("full_last_addr", 64'(last_wr_addr), 64'd255);
      chk("full_s_writes", 64'(s_wr_cnt - base_s), 64'(768 + 2 * 255));

      pt_mem[0] = 8'd20;
      push_exp(24'hA1B2C3);
      base_ct = ct_wr_cnt;
      start_job(24'hA1B2C3);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         en  = c[0];
         key = 24'h5E4D3C ^ 24'(c);
      end
      en = 1'b0;
      run_wait("disturb", 6000, -1);
      chk("disturb_left", 64'(exp_q.size()), 64'd0);
      chk("disturb_ct_count", 64'(ct_wr_cnt - base_ct), 64'd21);
      repeat (30) @(negedge clk);
      chk("disturb_no_second_job", 64'(ct_wr_cnt - base_ct), 64'd21);

      for (int n = 0; n < 10; n++) pt_mem[n] = kat_pt[n];
      push_exp(24'h4B6579);
      start_job(24'h4B6579);
      run_wait("abort", 6000, 3);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_ct_wren", 64'(ct_wren), 64'd0);
      chk("abort_rdy", 64'(rdy), 64'd1);
      exp_q.delete();
      base_ct = rst_wr_cnt;
      repeat (3) @(negedge clk);
      chk("abort_rdy_held", 64'(rdy), 64'd1);
      chk("abort_no_writes", 64'(rst_wr_cnt - base_ct), 64'd0);
      rst_n = 1'b1;
      run_job("rerun", 24'h4B6579);
      for (int n = 0; n < 10; n++) chk($sformatf("rerun_byte%0d", n), 64'(ct_mem[n]), 64'(kat_ct[n]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
